// File: rtl/ysyx_23060042_alu_arb.sv
// Two-requester arbiter in front of a single shared 32-bit ALU (IDLE -> EXEC -> RESP).
// Define YSYX_23060042_ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority (requester 0 wins).

module ysyx_23060042_ALU (
    input  logic [2:0]  i_aluop,
    input  logic        i_unsign,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result
);

    // Less-than flag; i_unsign selects unsigned compare
    function automatic logic f_lt(input logic [31:0] a, input logic [31:0] b, input logic uns);
        logic r;
        if (uns) begin
            r = (a < b);
        end else begin
            r = ($signed(a) < $signed(b));
        end
        return r;
    endfunction

    logic [4:0] w_shamt;
    assign w_shamt = i_b[4:0];

    // Operation decode
    always_comb begin
        o_result = 32'd0;
        case (i_aluop)
            3'b000:  o_result = i_a + i_b;
            3'b001:  o_result = i_a - i_b;
            3'b010:  o_result = i_a << w_shamt;
            3'b011: begin
                if (i_unsign) begin
                    o_result = i_a >> w_shamt;
                end else begin
                    o_result = $unsigned($signed(i_a) >>> w_shamt);
                end
            end
            3'b100:  o_result = i_a | i_b;
            3'b101:  o_result = i_a ^ i_b;
            3'b110:  o_result = i_a & i_b;
            3'b111:  o_result = {31'd0, f_lt(i_a, i_b, i_unsign)};
            default: o_result = 32'd0;
        endcase
    end

endmodule

module ysyx_23060042_alu_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_aluop,
    input  logic        req0_unsign,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_aluop,
    input  logic        req1_unsign,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp_data,
    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [2:0]  r_op;
    logic        r_uns;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_resp_data;
    logic        r_grant_id;
`ifdef YSYX_23060042_ALU_ARB_RR_EN
    logic        r_rr_ptr;
`endif

    logic        w_any_valid;
    logic        w_win_id;
    logic        w_accept;
    logic        w_resp_ready;
    logic        w_resp_fire;
    logic [31:0] w_alu_result;

    assign w_any_valid = req0_valid | req1_valid;

    // Winner selection among pending requesters
    always_comb begin
        w_win_id = 1'b0;
`ifdef YSYX_23060042_ALU_ARB_RR_EN
        if (req0_valid && req1_valid) begin
            w_win_id = r_rr_ptr;
        end else if (req1_valid) begin
            w_win_id = 1'b1;
        end else begin
            w_win_id = 1'b0;
        end
`else
        if (req0_valid) begin
            w_win_id = 1'b0;
        end else begin
            w_win_id = 1'b1;
        end
`endif
    end

    // Handshakes are suppressed while rst is high so nothing leaks during reset
    assign w_accept     = (r_state == ST_IDLE) && w_any_valid && !rst;
    assign w_resp_ready = r_grant_id ? resp1_ready : resp0_ready;
    assign w_resp_fire  = (r_state == ST_RESP) && w_resp_ready && !rst;

    assign req0_ready  = w_accept && !w_win_id;
    assign req1_ready  = w_accept &&  w_win_id;
    assign resp0_valid = (r_state == ST_RESP) && !r_grant_id && !rst;
    assign resp1_valid = (r_state == ST_RESP) &&  r_grant_id && !rst;
    assign resp_data   = r_resp_data;
    assign busy        = (r_state != ST_IDLE);
    assign grant_id    = r_grant_id;

    ysyx_23060042_ALU u_alu (
        .i_aluop  (r_op),
        .i_unsign (r_uns),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_result)
    );

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (w_resp_fire) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_resp_data <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_EXEC) begin
                r_resp_data <= w_alu_result;
            end else begin
                r_resp_data <= r_resp_data;
            end
        end
    end

    // Operand latch on accept; the ALU only ever sees these registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= 3'd0;
            r_uns      <= 1'b0;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_grant_id <= 1'b0;
        end else if (w_accept) begin
            r_grant_id <= w_win_id;
            if (w_win_id) begin
                r_op  <= req1_aluop;
                r_uns <= req1_unsign;
                r_a   <= req1_a;
                r_b   <= req1_b;
            end else begin
                r_op  <= req0_aluop;
                r_uns <= req0_unsign;
                r_a   <= req0_a;
                r_b   <= req0_b;
            end
        end else begin
            r_grant_id <= r_grant_id;
        end
    end

`ifdef YSYX_23060042_ALU_ARB_RR_EN
    // Pointer names the preferred requester for the next tie
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
        end else if (w_accept) begin
            r_rr_ptr <= ~w_win_id;
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end
`endif

endmodule
